// File: rtl/duty_cycle_circuit_if.sv
// duty_cycle_circuit_if: groups the measured input, the enable and the published
// result of duty_cycle_circuit. The driver/reader side uses the master modport and
// the measurement block uses the slave modport.
interface duty_cycle_circuit_if;
    logic       ring_in;   // asynchronous signal under measurement
    logic       enable;    // synchronous measurement enable
    logic [7:0] value;     // last published duty-cycle result

    modport master (output ring_in, output enable, input value);
    modport slave  (input ring_in, input enable, output value);
endinterface

// File: rtl/duty_cycle_circuit.sv
// duty_cycle_circuit: oversamples an asynchronous input over WINDOW enabled clock
// cycles and publishes the high-sample count on value at each window end.
// Optional macro DUTY_CYCLE_PERCENT_EN: publish floor(count*100/WINDOW) instead,
// computed by an 8-iteration restoring divider that adds 9 cycles of latency.
module duty_cycle_circuit #(
    parameter int WINDOW = 255   // samples per window, legal range 16..255
) (
    input  logic                 clk,
    input  logic                 reset,
    duty_cycle_circuit_if.slave  bus
);

    localparam logic [7:0] LAST_IDX = 8'(WINDOW - 1);

    logic [1:0] sync_q, sync_d;     // [0] first stage, [1] synchronized sample
    logic [7:0] wcnt_q, wcnt_d;
    logic [7:0] hcnt_q, hcnt_d;
    logic [7:0] value_q, value_d;
    logic       s;
    logic       win_end;
    logic [7:0] final_cnt;

    assign s         = sync_q[1];
    assign bus.value = value_q;

    // Two-flop synchronizer for ring_in; keeps running regardless of enable.
    always_comb begin
        sync_d = {sync_q[0], bus.ring_in};
    end

    // Window and high-sample counters; flag the edge that consumes the last sample.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
        wcnt_d    = wcnt_q;
        hcnt_d    = hcnt_q;
        win_end   = 1'b0;
        final_cnt = hcnt_q + {7'd0, s};
        if (!bus.enable) begin
            wcnt_d = '0;
            hcnt_d = '0;
        end else if (wcnt_q == LAST_IDX) begin
            win_end = 1'b1;
            wcnt_d  = '0;
            hcnt_d  = '0;
        end else begin
            wcnt_d = wcnt_q + 8'd1;
            hcnt_d = final_cnt;
        end
    end

`ifdef DUTY_CYCLE_PERCENT_EN
    // Quotient is at most 100, so the dividend's top 7 bits are already below the
    // divisor and only the low 8 dividend bits need to be shifted through.
    logic        div_busy_q, div_busy_d;
    logic [3:0]  div_cnt_q,  div_cnt_d;
    logic [7:0]  div_rem_q,  div_rem_d;
    logic [7:0]  div_lo_q,   div_lo_d;
    logic [7:0]  div_quo_q,  div_quo_d;
    logic [14:0] product;
    logic [8:0]  trial;
    logic        trial_ge;

    assign product  = 15'(final_cnt) * 15'd100;
    assign trial    = {div_rem_q, div_lo_q[7]};
    assign trial_ge = (trial >= 9'(WINDOW));

    // Divider: load at window end, 8 restoring iterations, publish on the 9th edge.
    always_comb begin
        div_busy_d = div_busy_q;
        div_cnt_d  = div_cnt_q;
        div_rem_d  = div_rem_q;
        div_lo_d   = div_lo_q;
        div_quo_d  = div_quo_q;
        value_d    = value_q;
        if (win_end) begin
            div_busy_d = 1'b1;
            div_cnt_d  = '0;
            div_rem_d  = {1'b0, product[14:8]};
            div_lo_d   = product[7:0];
            div_quo_d  = '0;
        end else if (div_busy_q) begin
            if (div_cnt_q == 4'd8) begin
                value_d    = div_quo_q;
                div_busy_d = 1'b0;
            end else begin
                div_rem_d = trial_ge ? 8'(trial - 9'(WINDOW)) : trial[7:0];
                div_lo_d  = {div_lo_q[6:0], 1'b0};
                div_quo_d = {div_quo_q[6:0], trial_ge};
                div_cnt_d = div_cnt_q + 4'd1;
            end
        end
    end

    // Divider state; reset aborts any divide in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_busy_q <= 1'b0;
            div_cnt_q  <= '0;
            div_rem_q  <= '0;
            div_lo_q   <= '0;
            div_quo_q  <= '0;
        end else begin
            div_busy_q <= div_busy_d;
            div_cnt_q  <= div_cnt_d;
            div_rem_q  <= div_rem_d;
            div_lo_q   <= div_lo_d;
            div_quo_q  <= div_quo_d;
        end
    end
`else
    // Raw mode: publish the final high-sample count at window end.
    always_comb begin
        value_d = win_end ? final_cnt : value_q;
    end
`endif

    // Measurement state: synchronizer, counters and published result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            wcnt_q  <= '0;
            hcnt_q  <= '0;
            value_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
            sync_q  <= sync_d;
            wcnt_q  <= wcnt_d;
            hcnt_q  <= hcnt_d;
            value_q <= value_d;
        end
    end

endmodule

// File: tb/tb_duty_cycle_circuit.sv
// tb_duty_cycle_circuit: directed stimulus with hand-computed results pushed into
// per-DUT expectation queues; a negedge monitor applies each expectation from its
// publish cycle onward and compares value every cycle.
module tb_duty_cycle_circuit;

    localparam int W_A = 200;
    localparam int W_B = 255;
`ifdef DUTY_CYCLE_PERCENT_EN
    localparam int LAT = 9;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;

    typedef enum {P_LOW, P_HIGH, P_QUARTER, P_BURST} pat_e;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic [7:0] cur_a = 8'd0;
    logic [7:0] cur_b = 8'd0;
    pat_e pat;
    int   burst_lo;
    int   wend_a;
    int   wend_b;

    duty_cycle_circuit_if if_a ();
    duty_cycle_circuit_if if_b ();

    duty_cycle_circuit #(.WINDOW(W_A)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
    duty_cycle_circuit #(.WINDOW(W_B)) dut_b (.clk(clk), .reset(reset), .bus(if_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] sel(input int raw, input int pct);
`ifdef DUTY_CYCLE_PERCENT_EN
        return 8'(pct);
`else
        return 8'(raw);
`endif
    endfunction

    task automatic push_a(input int c, input int raw, input int pct);
        exp_t e;
        e.cyc = c;
        e.val = sel(raw, pct);
        q_a.push_back(e);
    endtask

    task automatic push_b(input int c, input int raw, input int pct);
        exp_t e;
        e.cyc = c;
        e.val = sel(raw, pct);
        q_b.push_back(e);
    endtask

    task automatic drive_ring();
        logic r;
        case (pat)
            P_HIGH:    r = 1'b1;
            P_QUARTER: r = ((cyc % 4) == 0);
            P_BURST:   r = (cyc >= burst_lo) && (cyc < burst_lo + 128);
            default:   r = 1'b0;
        endcase
        if_a.ring_in = r;
        if_b.ring_in = r;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            drive_ring();
        end
    endtask

    task automatic start_en_a();
        if_a.enable = 1'b1;
        wend_a = cyc + W_A;
    endtask

    // Assert reset mid-cycle, check the asynchronous clear, release after the next edge.
    task automatic do_reset();
        exp_t e;
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_a", {24'd0, if_a.value}, 32'd0);
        check("async_reset_b", {24'd0, if_b.value}, 32'd0);
        q_a.delete();
        q_b.delete();
        e.cyc = cyc;
        e.val = 8'd0;
        q_a.push_back(e);
        q_b.push_back(e);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_ring();
    endtask

    // Monitor: apply due expectations, then compare both outputs.
    always @(negedge clk) begin
        exp_t e;
        while (q_a.size() > 0 && q_a[0].cyc <= cyc) begin
            e = q_a.pop_front();
            cur_a = e.val;
        end
        while (q_b.size() > 0 && q_b[0].cyc <= cyc) begin
            e = q_b.pop_front();
            cur_b = e.val;
        end
        check("value_a", {24'd0, if_a.value}, {24'd0, cur_a});
        check("value_b", {24'd0, if_b.value}, {24'd0, cur_b});
    end

    initial begin
        reset       = 1'b1;
        pat         = P_LOW;
        burst_lo    = 0;
        if_a.enable = 1'b0;
        if_b.enable = 1'b0;
        drive_ring();
        step(2);
        check("reset_state_a", {24'd0, if_a.value}, 32'd0);
        reset = 1'b0;
        step(2);

        // Constant high: full-scale count.
        pat = P_HIGH;
        step(4);
        start_en_a();
        push_a(wend_a + LAT, 200, 100);
        step(W_A);
        if_a.enable = 1'b0;

        // Constant low.
        pat = P_LOW;
        step(4);
        start_en_a();
        push_a(wend_a + LAT, 0, 0);
        step(W_A);
        if_a.enable = 1'b0;

        // Quarter duty over three back-to-back windows.
        pat = P_QUARTER;
        step(4);
        start_en_a();
        for (int i = 0; i < 3; i++)
            push_a(wend_a + i * W_A + LAT, 50, 25);
        step(3 * W_A);
        if_a.enable = 1'b0;

        // Enable drop after 100 low samples: partial window discarded, old value held.
        pat = P_LOW;
        step(4);
        start_en_a();
        step(100);
        if_a.enable = 1'b0;
        pat = P_HIGH;
        step(10);
        start_en_a();
        push_a(wend_a + LAT, 200, 100);
        step(W_A);

        // Reset mid-window; synchronizer restarts empty so the first window sees 198 highs.
        step(50);
        do_reset();
        wend_a = cyc + W_A;
        push_a(wend_a + LAT, 198, 99);
        step(W_A + 3);

        // Reset just after a window end (mid-divide in percent mode).
        do_reset();
        wend_a = cyc + W_A;
        push_a(wend_a + LAT, 198, 99);
        step(W_A + LAT + 3);
        if_a.enable = 1'b0;

        // WINDOW=255 with 128 high samples: floor(12800/255) = 50.
        pat      = P_BURST;
        burst_lo = cyc + 1;
        step(3);
        if_b.enable = 1'b1;
        wend_b = cyc + W_B;
        push_b(wend_b + LAT, 128, 50);
        step(W_B);
        if_b.enable = 1'b0;
        step(LAT + 4);

        check("sb_drain_a", q_a.size(), 32'd0);
        check("sb_drain_b", q_b.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
